// File: rtl/mem_cache_ctrl.sv
// Direct-mapped write-through cache (one word per line) between the CPU memory port and async_mem.
// Latency: read hit and write complete in the request cycle; read miss completes MEM_LATENCY+1 cycles after the request.
// Backpressure: cpu_ready stays low through a fill, and the CPU holds its request until cpu_ready rises.
module mem_cache_ctrl #(
   parameter int IDX_BITS    = 4,
   parameter int MEM_LATENCY = 3
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cpu_read,
   input  logic        cpu_write,
   input  logic [31:0] cpu_addr,
   input  logic [31:0] cpu_write_data,
   output logic [31:0] cpu_read_data,
   output logic        cpu_ready,
   output logic        mem_read,
   output logic        mem_write,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_write_data,
   input  logic [31:0] mem_read_data,
   input  logic        flush,
   output logic [15:0] hit_count,
   output logic [15:0] miss_count
);

   localparam int LINES = 1 << IDX_BITS;
   localparam int TAG_W = 30 - IDX_BITS;
   localparam int CW    = $clog2(MEM_LATENCY + 1);

   typedef enum logic {IDLE, FILL} state_t;

   state_t                state, next_state;
   logic [CW-1:0]         fill_cnt;
   logic [LINES-1:0]      valid;
   logic [TAG_W-1:0]      tag_arr [LINES];
   logic [31:0]           data_arr [LINES];
   logic                  fill_done;

   logic [IDX_BITS-1:0]   idx;
   logic [TAG_W-1:0]      tag;
   logic                  hit;
   logic                  install;
   logic                  rd_hit;
   logic                  rd_miss;
   logic                  wr_hit;

   assign idx     = cpu_addr[IDX_BITS+1:2];
   assign tag     = cpu_addr[31:IDX_BITS+2];
   assign hit     = valid[idx] && (tag_arr[idx] == tag);
   assign install = (state == FILL) && (fill_cnt == CW'(MEM_LATENCY));
   assign rd_hit  = (state == IDLE) && cpu_read && !cpu_write && hit;
   assign rd_miss = (state == IDLE) && cpu_read && !cpu_write && !hit;
   assign wr_hit  = (state == IDLE) && cpu_write && hit;

   // State register, fill counter, valid bits and statistics.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         fill_cnt   <= '0;
         valid      <= '0;
         fill_done  <= 1'b0;
         hit_count  <= '0;
         miss_count <= '0;
      end else begin
         state     <= next_state;
         fill_done <= install;
         if (rd_miss) begin
            fill_cnt <= CW'(1);
         end else if ((state == FILL) && !install) begin
            fill_cnt <= fill_cnt + CW'(1);
         end
         // A fill landing on the flush edge keeps its line: the data is fresh from memory.
         if (flush) begin
            valid <= '0;
         end
         if (install) begin
            valid[idx] <= 1'b1;
         end
         // The hit that completes a fill is the tail of a miss, not a separate hit.
         if (rd_hit && !fill_done && (hit_count != 16'hFFFF)) begin
            hit_count <= hit_count + 16'd1;
         end
         if (rd_miss && (miss_count != 16'hFFFF)) begin
            miss_count <= miss_count + 16'd1;
         end
      end
   end

   // Line storage: fills install tag+data, write hits refresh data only.
   always_ff @(posedge clk) begin
      if (install) begin
         data_arr[idx] <= mem_read_data;
         tag_arr[idx]  <= tag;
      end else if (wr_hit) begin
         data_arr[idx] <= cpu_write_data;
      end
   end

   // Next state and handshake outputs; all handshakes forced low while reset is held.
   always_comb begin
      next_state     = state;
      cpu_ready      = 1'b0;
      cpu_read_data  = data_arr[idx];
      mem_read       = 1'b0;
      mem_write      = 1'b0;
      mem_addr       = '0;
      mem_write_data = '0;
      if (reset) begin
         case (state)
            IDLE: begin
               if (cpu_write) begin
                  mem_write      = 1'b1;
                  mem_addr       = cpu_addr;
                  mem_write_data = cpu_write_data;
                  cpu_ready      = 1'b1;
               end else if (cpu_read) begin
                  if (hit) begin
                     cpu_ready = 1'b1;
                  end else begin
                     next_state = FILL;
                  end
               end
            end
            FILL: begin
               mem_read = 1'b1;
               mem_addr = cpu_addr;
               if (install) begin
                  next_state = IDLE;
               end
            end
            default: next_state = IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_cache_ctrl.sv
// Directed bench for mem_cache_ctrl with a behavioural async_mem word array.
// Inputs change 1 time unit after posedge; outputs are sampled on negedge.
// Every comparison goes through check(), which counts and asserts.
module tb_mem_cache_ctrl;

   localparam int LAT = 3;

   logic        clk;
   logic        reset;
   logic        cpu_read;
   logic        cpu_write;
   logic [31:0] cpu_addr;
   logic [31:0] cpu_write_data;
   logic [31:0] cpu_read_data;
   logic        cpu_ready;
   logic        mem_read;
   logic        mem_write;
   logic [31:0] mem_addr;
   logic [31:0] mem_write_data;
   logic [31:0] mem_read_data;
   logic        flush;
   logic [15:0] hit_count;
   logic [15:0] miss_count;

   logic [31:0] mem [4096];

   int checks = 0;
   int errors = 0;

   mem_cache_ctrl #(.IDX_BITS(4), .MEM_LATENCY(LAT)) dut (
      .clk            (clk),
      .reset          (reset),
      .cpu_read       (cpu_read),
      .cpu_write      (cpu_write),
      .cpu_addr       (cpu_addr),
      .cpu_write_data (cpu_write_data),
      .cpu_read_data  (cpu_read_data),
      .cpu_ready      (cpu_ready),
      .mem_read       (mem_read),
      .mem_write      (mem_write),
      .mem_addr       (mem_addr),
      .mem_write_data (mem_write_data),
      .mem_read_data  (mem_read_data),
      .flush          (flush),
      .hit_count      (hit_count),
      .miss_count     (miss_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Behavioural memory: combinational read, write at posedge.
   assign mem_read_data = mem[mem_addr[13:2]];
   always @(posedge clk) begin
      if (mem_write) mem[mem_addr[13:2]] = mem_write_data;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Hold a read until cpu_ready; check completion cycle, mem_read cycles and data.
   task automatic do_read(input string tag, input logic [31:0] addr,
                          input logic [31:0] exp_data, input int exp_lat);
      int  cyc  = 0;
      int  mr   = 0;
      bit  done = 0;
      cpu_addr = addr;
      cpu_read = 1'b1;
      while (!done && cyc < 20) begin
         @(negedge clk);
         if (mem_read) mr++;
         if (cpu_ready) begin
            done = 1;
            check({tag, "_lat"}, 32'(cyc), 32'(exp_lat));
            check({tag, "_data"}, cpu_read_data, exp_data);
            check({tag, "_memrd"}, 32'(mr), (exp_lat == 0) ? 32'd0 : 32'(LAT));
         end else begin
            cyc++;
         end
         @(posedge clk);
         #1;
      end
      if (!done) check({tag, "_timeout"}, 32'd0, 32'd1);
      cpu_read = 1'b0;
   endtask

   // Single-cycle write; checks the memory port and the memory word afterwards.
   task automatic do_write(input string tag, input logic [31:0] addr, input logic [31:0] data);
      cpu_addr       = addr;
      cpu_write_data = data;
      cpu_write      = 1'b1;
      @(negedge clk);
      check({tag, "_mw"}, 32'(mem_write), 32'd1);
      check({tag, "_maddr"}, mem_addr, addr);
      check({tag, "_mwdat"}, mem_write_data, data);
      check({tag, "_rdy"}, 32'(cpu_ready), 32'd1);
      @(posedge clk);
      #1;
      cpu_write = 1'b0;
      check({tag, "_memword"}, mem[addr[13:2]], data);
   endtask

   initial begin
      reset          = 1'b0;
      cpu_read       = 1'b0;
      cpu_write      = 1'b1;
      cpu_addr       = 32'h0000_3000;
      cpu_write_data = 32'h1111_1111;
      flush          = 1'b0;
      mem[32'h3000 >> 2 & 32'hFFF] = 32'h1234_5678;
      mem[32'h3040 >> 2 & 32'hFFF] = 32'hCAFE_0040;
      mem[32'h3080 >> 2 & 32'hFFF] = 32'h0000_0000;
      mem[32'h3004 >> 2 & 32'hFFF] = 32'hA5A5_0004;

      // Reset state, with a write request present that must be masked.
      #2;
      check("rst_rdy", 32'(cpu_ready), 32'd0);
      check("rst_mw", 32'(mem_write), 32'd0);
      check("rst_mr", 32'(mem_read), 32'd0);
      check("rst_maddr", mem_addr, 32'd0);
      check("rst_mwdat", mem_write_data, 32'd0);
      check("rst_hits", 32'(hit_count), 32'd0);
      check("rst_miss", 32'(miss_count), 32'd0);
      cpu_write = 1'b0;
      #10;
      reset = 1'b1;
      @(posedge clk);
      #1;

      // Cold miss then immediate re-read hit.
      do_read("cold", 32'h3000, 32'h1234_5678, LAT + 1);
      check("cold_miss", 32'(miss_count), 32'd1);
      check("cold_hits", 32'(hit_count), 32'd0);
      do_read("reread", 32'h3000, 32'h1234_5678, 0);
      check("reread_hits", 32'(hit_count), 32'd1);

      // Write hit updates memory and the cached line.
      do_write("wrhit", 32'h3000, 32'hDEAD_BEEF);
      check("wrhit_hits", 32'(hit_count), 32'd1);
      do_read("rdafterwr", 32'h3000, 32'hDEAD_BEEF, 0);
      check("rdafterwr_hits", 32'(hit_count), 32'd2);

      // Conflicts on index 0 and a non-allocating write miss.
      do_read("conf3040", 32'h3040, 32'hCAFE_0040, LAT + 1);
      do_read("conf3000", 32'h3000, 32'hDEAD_BEEF, LAT + 1);
      check("conf_miss", 32'(miss_count), 32'd3);
      do_write("wrmiss", 32'h3080, 32'h55AA_55AA);
      do_read("rd3080", 32'h3080, 32'h55AA_55AA, LAT + 1);
      check("rd3080_miss", 32'(miss_count), 32'd4);
      check("rd3080_hits", 32'(hit_count), 32'd2);

      // Flush drops a cached line.
      do_read("recache", 32'h3000, 32'hDEAD_BEEF, LAT + 1);
      do_read("cachedhit", 32'h3000, 32'hDEAD_BEEF, 0);
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      do_read("postflush", 32'h3000, 32'hDEAD_BEEF, LAT + 1);
      check("flush_miss", 32'(miss_count), 32'd6);
      check("flush_hits", 32'(hit_count), 32'd3);

      // Reset in FILL cycle 2.
      cpu_addr = 32'h3004;
      cpu_read = 1'b1;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      @(negedge clk);
      check("mid_mr", 32'(mem_read), 32'd1);
      check("mid_miss", 32'(miss_count), 32'd7);
      #1;
      reset = 1'b0;
      #1;
      check("midrst_mr", 32'(mem_read), 32'd0);
      check("midrst_rdy", 32'(cpu_ready), 32'd0);
      check("midrst_miss", 32'(miss_count), 32'd0);
      check("midrst_hits", 32'(hit_count), 32'd0);
      cpu_read = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      do_read("afterrst", 32'h3004, 32'hA5A5_0004, LAT + 1);
      check("afterrst_miss", 32'(miss_count), 32'd1);
      check("afterrst_hits", 32'(hit_count), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_cache_ctrl.md
Name: mem_cache_ctrl

Overview:
- Direct-mapped, write-through, one-word-per-line cache between the multi_cycle_mips memory port and async_mem.
- Absorbs async_mem's multi-cycle read latency: read hits complete in zero wait cycles; misses stall the CPU through cpu_ready.
- Also provides a bulk invalidate and hit/miss statistics counters for bench reporting.

Parameters:
- IDX_BITS, 4, index width; lines = 2**IDX_BITS.
- MEM_LATENCY, 3, cycles mem_read is held before mem_read_data is sampled. 3 covers the 7 ns memory at a 2.5 ns clock.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low reset.
- cpu_read  in  1  CPU read request; held until cpu_ready.
- cpu_write  in  1  CPU write request; held until cpu_ready.
- cpu_addr  in  32  byte address; bits [1:0] ignored.
- cpu_write_data  in  32  store data.
- cpu_read_data  out  32  load data; valid only while cpu_ready=1 with cpu_read=1.
- cpu_ready  out  1  request completes at this posedge.
- mem_read  out  1  to async_mem read.
- mem_write  out  1  to async_mem write.
- mem_addr  out  32  to async_mem address.
- mem_write_data  out  32  to async_mem write_data.
- mem_read_data  in  32  from async_mem read_data.
- flush  in  1  invalidate all lines.
- hit_count  out  16  saturating read-hit counter.
- miss_count  out  16  saturating read-miss counter.

Behaviour:
- Address split:
  - index = cpu_addr[IDX_BITS+1:2]
  - tag = cpu_addr[31:IDX_BITS+2]
  - hit = valid[index] & (tag_arr[index] == tag)
- Storage: valid bit, tag and 32-bit data per line, in registers.
- Reset (reset=0, asynchronous):
  - all valid bits cleared, state=IDLE, fill counter=0, hit_count=miss_count=0.
  - cpu_ready=0, mem_read=0, mem_write=0, mem_addr=0, mem_write_data=0.
  - Tag and data contents are don't-care.
- FSM states: IDLE, FILL.
- IDLE, cpu_write=1 (takes priority over cpu_read if both are set):
  - combinationally: mem_write=1, mem_addr=cpu_addr, mem_write_data=cpu_write_data, cpu_ready=1.
  - on a hit, the line data is updated at the same edge.
  - on a miss, nothing is allocated.
  - Stays in IDLE; a write takes 1 cycle.
- IDLE, cpu_read=1, hit:
  - cpu_ready=1 and cpu_read_data=data[index] combinationally.
  - hit_count increments (saturates at 16'hFFFF).
  - Total read-hit latency: 1 cycle.
- IDLE, cpu_read=1, miss:
  - cpu_ready=0; go to FILL with counter=1; miss_count increments (saturating).
- FILL:
  - mem_read=1, mem_addr=cpu_addr, cpu_ready=0.
  - counter increments each cycle.
  - At the edge ending the cycle where counter==MEM_LATENCY: write mem_read_data into data[index], set tag_arr[index]=tag and valid[index]=1, then return to IDLE.
  - The next IDLE cycle is a hit and completes the read, so total miss latency = MEM_LATENCY+1 cycles. That completing hit does NOT increment hit_count.
- Outputs outside the above cases: mem_read=0 and mem_write=0 outside FILL and outside IDLE writes. cpu_read_data when not ready is don't-care.
- No request in IDLE: all handshake outputs are 0.
- flush=1:
  - clears all valid bits at the edge.
  - If the same edge also completes a FILL install, the installed line remains valid (its data came fresh from memory).
  - A write hit coinciding with flush: memory is still written and the line ends invalid.
- CPU request inputs must be stable while cpu_ready=0. Changing them mid-FILL is a protocol violation; the block behaviour is then undefined, and the bench must not do it.
- Reset asserted mid-FILL: mem_read drops immediately (asynchronously), and no line is installed.
- Counters never wrap; they are cleared only by reset.

Test Plan:
- Cold read miss: mem[0x3000>>2]=32'h12345678, MEM_LATENCY=3, read 0x3000.
  - Required: mem_read high for exactly 3 cycles, cpu_ready=1 in cycle 4 with data 32'h12345678.
  - Required: miss_count=1, hit_count=0.
- Re-read 0x3000 immediately after the cold miss.
  - Required: cpu_ready=1 in the same cycle, data 32'h12345678, mem_read stays 0, hit_count=1.
- Write hit: write 32'hDEADBEEF to 0x3000.
  - Required: mem_write for one cycle, and memory word = DEADBEEF after that posedge.
  - Then read 0x3000: required hit returning DEADBEEF.
- Conflict and write miss:
  - Read 0x3040 (same index 0 as 0x3000): required miss, which evicts 0x3000.
  - Read 0x3000: required miss again.
  - Write miss to 0x3080: required memory written, then a read of 0x3080 misses.
- Flush: with 0x3000 cached, pulse flush for 1 cycle, then read 0x3000.
  - Required: full miss (MEM_LATENCY+1 cycles), miss_count increments.
- Reset mid-fill: drive reset=0 in FILL cycle 2.
  - Required: mem_read=0, cpu_ready=0 and counters=0 immediately.
  - After release, a read of the same address misses.
